// File: rtl/onewire_rom_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onewire_rom_reader
// Description : Issues 64 1-Wire master read slots after READ ROM, assembles
//               the returned ROM code LSB first and checks its CRC-8
//               (x^8 + x^5 + x^4 + 1, reflected constant 0x8C).
// Revision    : 1.0 - initial release
// ============================================================================
module onewire_rom_reader #(
   parameter int T_LOW    = 6,
   parameter int T_SAMPLE = 14,
   parameter int T_SLOT   = 60,
   parameter int T_REC    = 11,
   parameter int N_BITS   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   inout  wire               bus,
   output logic              busy,
   output logic              done,
   output logic [N_BITS-1:0] rom_code,
   output logic              crc_ok
);

   localparam int c_CNT_W = $clog2(T_SLOT + T_REC);
   localparam logic [c_CNT_W-1:0] c_LOW      = c_CNT_W'(T_LOW);
   localparam logic [c_CNT_W-1:0] c_SAMPLE   = c_CNT_W'(T_SAMPLE);
   localparam logic [c_CNT_W-1:0] c_SLOT_END = c_CNT_W'(T_SLOT + T_REC - 1);
   localparam logic [6:0]         c_LAST_BIT = 7'(N_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SLOT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [6:0]          r_bit_cnt;
   logic [7:0]          r_crc;
   logic [N_BITS-1:0]   r_rom;
   logic                r_crc_ok;
   logic                r_sync1;
   logic                r_sync2;
   logic                w_slot_end;
   logic                w_sample;
   logic                w_fb;
   logic                w_drive_low;

   assign w_slot_end  = (r_state == S_SLOT) && (r_cnt == c_SLOT_END);
   assign w_sample    = (r_state == S_SLOT) && (r_cnt == c_SAMPLE);
   assign w_fb        = r_crc[0] ^ r_sync2;

   // Open-drain drive derived from the async-reset state, so reset releases
   // the line immediately.
   assign w_drive_low = (r_state == S_SLOT) && (r_cnt < c_LOW);
   assign bus         = w_drive_low ? 1'b0 : 1'bz;

   assign busy     = (r_state == S_SLOT);
   assign done     = (r_state == S_DONE);
   assign rom_code = r_rom;
   assign crc_ok   = r_crc_ok;

   // Two-flop synchronizer for the asynchronous bus level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus;
         r_sync2 <= r_sync1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SLOT;
         S_SLOT:  if (w_slot_end && (r_bit_cnt == c_LAST_BIT)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Slot timing, bit capture, CRC accumulation and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_crc     <= '0;
         r_rom     <= '0;
         r_crc_ok  <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_crc     <= '0;
            r_rom     <= '0;
            r_crc_ok  <= 1'b0;
         end else if (r_state == S_SLOT) begin
            if (w_sample) begin
               r_rom <= {r_sync2, r_rom[N_BITS-1:1]};
               r_crc <= (r_crc >> 1) ^ (w_fb ? 8'h8C : 8'h00);
            end
            if (w_slot_end) begin
               r_cnt     <= '0;
               r_bit_cnt <= r_bit_cnt + 7'd1;
               // The last capture happened earlier in this slot, so the CRC
               // is final here and crc_ok is valid alongside done.
               if (r_bit_cnt == c_LAST_BIT) begin
                  r_crc_ok <= (r_crc == 8'h00);
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_onewire_rom_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_onewire_rom_reader
// Description : Self-checking bench for onewire_rom_reader with a behavioural
//               1-Wire slave (pull-up bus, 1 clk = 10 ns = 1 us).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onewire_rom_reader;

   localparam int c_BIT_CYC  = 71;
   localparam int c_DONE_CYC = 64 * c_BIT_CYC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   wire         bus;
   logic        busy;
   logic        done;
   logic [63:0] rom_code;
   logic        crc_ok;

   // Slave model state.
   logic        s_en = 1'b0;
   logic        s_low = 1'b0;
   logic [63:0] s_code = '0;
   int          s_mode = 0;   // 0 random hold, 1 short (~13 us), 2 long (~45 us)
   int          s_idx = 0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          falls[$];
   int          widths[$];

   pullup (bus);
   assign bus = s_low ? 1'b0 : 1'bz;

   onewire_rom_reader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .rom_code (rom_code),
      .crc_ok   (crc_ok)
   );

   always #5 clk = ~clk;

   // Slave: on each master falling edge send the next code bit; a 0 is a
   // low pulse held past the master's release.
   always @(negedge bus or negedge rst_n) begin
      if (!rst_n) begin
         s_idx = 0;
      end else if (s_en && !s_low) begin
         if (!s_code[s_idx[5:0]]) begin
            s_low = 1'b1;
            if (s_mode == 1)      #133;
            else if (s_mode == 2) #450;
            else                  #($urandom_range(450, 133));
            s_low = 1'b0;
         end
         s_idx = (s_idx + 1) % 64;
      end
   end

   // Dallas CRC-8 of the first nbytes bytes, processed byte by byte LSB first.
   function automatic logic [7:0] crc8(input logic [63:0] v, input int nbytes);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         b = v[8*i +: 8];
         for (int j = 0; j < 8; j++) begin
            if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
            else                       c = c >> 1;
            b = b >> 1;
         end
      end
      return c;
   endfunction

   function automatic logic model_ok(input logic [63:0] v);
      return crc8(v, 7) == v[63:56];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then watch the bus and done each cycle (bounded).
   // cyc = number of edges after the start-sampling edge when done is seen.
   task automatic run_read(input int p1, input int p2, output int cyc);
      int run;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      run = 0;
      falls.delete();
      widths.delete();
      while (cyc < 6000) begin
         if (bus === 1'b0) begin
            if (run == 0) falls.push_back(cyc);
            run++;
         end else if (run != 0) begin
            widths.push_back(run);
            run = 0;
         end
         if (done === 1'b1) break;
         @(posedge clk);
         #1;
         cyc++;
         start = (cyc == p1) || (cyc == p2);
      end
      start = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          nd;
      logic [63:0] code;
      logic [63:0] c_dir;

      c_dir = 64'hA200000001B81C02;

      // Reset values.
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #3;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rom", rom_code, 64'd0);
      check("rst_crc_ok", 64'(crc_ok), 64'd0);
      check("rst_bus_released", 64'(bus), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed reference code.
      s_en = 1'b1; s_mode = 0; s_code = c_dir;
      run_read(-1, -1, cyc);
      check("dir_done_cycle", 64'(cyc), 64'(c_DONE_CYC));
      check("dir_rom", rom_code, c_dir);
      check("dir_crc_ok", 64'(crc_ok), 64'd1);
      check("dir_busy_at_done", 64'(busy), 64'd0);

      // Start coinciding with done is ignored; results hold.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_at_done_busy", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
      check("rom_hold", rom_code, c_dir);
      check("crc_ok_hold", 64'(crc_ok), 64'd1);

      // Accepted on the very next cycle: bit 20 flipped.
      s_code = c_dir ^ (64'd1 << 20);
      run_read(-1, -1, cyc);
      check("flip_done_cycle", 64'(cyc), 64'(c_DONE_CYC));
      check("flip_rom", rom_code, c_dir ^ (64'd1 << 20));
      check("flip_crc_ok", 64'(crc_ok), 64'd0);

      // No slave: bus stays pulled high apart from master pulses.
      do_reset();
      s_en = 1'b0;
      run_read(-1, -1, cyc);
      check("noslave_rom", rom_code, 64'hFFFF_FFFF_FFFF_FFFF);
      check("noslave_crc_ok", 64'(crc_ok), 64'(model_ok(64'hFFFF_FFFF_FFFF_FFFF)));
      check("noslave_pulses", 64'(falls.size()), 64'd64);
      check("noslave_widths", 64'(widths.size()), 64'd64);
      check("first_fall_at_start", 64'(falls.size() > 0 ? falls[0] : -1), 64'd0);
      for (int i = 0; i < widths.size(); i++) begin
         check($sformatf("pulse_width_%0d", i), 64'(widths[i]), 64'd6);
      end
      for (int i = 1; i < falls.size(); i++) begin
         check($sformatf("pulse_spacing_%0d", i), 64'(falls[i] - falls[i-1]), 64'(c_BIT_CYC));
      end

      // Start while busy does not restart; exactly one done.
      do_reset();
      s_en = 1'b1; s_mode = 0; s_code = c_dir;
      run_read(100, 3000, cyc);
      check("busy_start_done_cycle", 64'(cyc), 64'(c_DONE_CYC));
      check("busy_start_rom", rom_code, c_dir);
      nd = 0;
      repeat (200) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) nd++;
      end
      check("no_second_done", 64'(nd), 64'd0);

      // Reset in slot 10 while the master holds the bus low.
      do_reset();
      s_en = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10 * c_BIT_CYC + 2) @(posedge clk);
      #1;
      check("slot10_bus_low", 64'(bus), 64'd0);
      check("slot10_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_bus_released", 64'(bus), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_rom", rom_code, 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      s_en = 1'b1; s_code = c_dir;
      run_read(-1, -1, cyc);
      check("after_rst_done_cycle", 64'(cyc), 64'(c_DONE_CYC));
      check("after_rst_rom", rom_code, c_dir);
      check("after_rst_crc_ok", 64'(crc_ok), 64'd1);

      // Short (~13 us) and long (~45 us) slave holds, plus random codes.
      for (int t = 0; t < 6; t++) begin
         code = {$urandom, $urandom};
         if (t % 2 == 0) code[63:56] = crc8(code, 7);
         s_mode = (t == 0) ? 1 : (t == 1) ? 2 : 0;
         s_code = code;
         do_reset();
         run_read(-1, -1, cyc);
         check($sformatf("rand%0d_done_cycle", t), 64'(cyc), 64'(c_DONE_CYC));
         check($sformatf("rand%0d_rom", t), rom_code, code);
         check($sformatf("rand%0d_crc_ok", t), 64'(crc_ok), 64'(model_ok(code)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
